nibble_serial_adder_ctrl: RTL and testbench

Sequencer that performs a wide (4*NIBBLES-bit) addition by time-multiplexing the team's existing 4-bit ripple-carry adder stage, one nibble per clock, LSB nibble first. It sits directly upstream of that adder: it drives the adder's e, f and carry_in inputs and consumes its sum and carry_out. The inter-nibble carry is registered between cycles. It presents a start/busy/done handshake to the surrounding datapath.

---
 rtl/nibble_serial_adder_ctrl.sv | 139 +++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Performs a 4*NIBBLES-bit addition by stepping an external combinational
// 4-bit ripple adder across the operands one nibble per clock, LSB first.
// The carry between nibbles is registered. start/busy/done handshake.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   overflow,
    output logic [3:0]             add_e,
    output logic [3:0]             add_f,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int W = 4 * NIBBLES;
    // One spare code point so an out-of-range idx is representable and detectable
    localparam int IDX_W = $clog2(NIBBLES + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             carry_r;
    logic             idx_valid;

    assign idx_valid = (idx <= LAST);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // State register; reset wins in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the nibble mux feeding the shared adder
    always_comb begin
        next_state = state;
        add_e      = 4'd0;
        add_f      = 4'd0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (idx_valid) begin
                    add_e   = a_r[4*idx +: 4];
                    add_f   = b_r[4*idx +: 4];
                    add_cin = carry_r;
                    if (idx == LAST) begin
                        next_state = DONE;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, per-nibble sum write-back, carry chain and final flags
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry_r  <= cin;
                        idx      <= '0;
                        result   <= '0;
                        cout     <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (idx_valid) begin
                        result[4*idx +: 4] <= add_sum;
                        carry_r            <= add_cout;
                        if (idx == LAST) begin
                            cout     <= add_cout;
                            overflow <= (a_r[W-1] == b_r[W-1]) && (add_sum[3] != a_r[W-1]);
                            idx      <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        idx <= '0;
                    end
                end
                DONE: begin
                    idx <= '0;
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl: models the 4-bit adder stage,
// runs a table of directed + random additions against an arithmetic
// reference, then hand-written start-ignore and mid-run reset sequences.
module tb_nibble_serial_adder_ctrl;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [W-1:0]     result;
    logic             cout;
    logic             overflow;
    logic [3:0]       add_e;
    logic [3:0]       add_f;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_result;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    int               busy_cnt;
    int               done_cnt;
    int               done_pos;
    logic [W-1:0]     e_packed;
    logic [W-1:0]     f_packed;
    logic [NIBBLES-1:0] cin_packed;
    logic [W-1:0]     result_at_done;

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .add_e    (add_e),
        .add_f    (add_f),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Stand-in for the team's combinational 4-bit ripple adder
    assign {add_cout, add_sum} = {1'b0, add_e} + {1'b0, add_f} + {4'b0, add_cin};

    always #5 clk = ~clk;

    // Carry entering nibble i is the carry out of the low 4*i bits of a+b+cin
    function automatic logic [NIBBLES-1:0] carryModel(input logic [W-1:0] ta,
                                                       input logic [W-1:0] tb_,
                                                       input logic tcin);
        logic [NIBBLES-1:0] c;
        logic [63:0] mask;
        logic [63:0] s;
        for (int i = 0; i < NIBBLES; i++) begin
            mask = (64'd1 << (4 * i)) - 64'd1;
            s = ({48'd0, ta} & mask) + ({48'd0, tb_} & mask) + {63'd0, tcin};
            c[i] = s[4 * i];
        end
        return c;
    endfunction

    function automatic vec_t refModel(input string name, input logic [W-1:0] ta,
                                      input logic [W-1:0] tb_, input logic tcin);
        vec_t v;
        logic [W:0] s;
        s = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tcin};
        v.name       = name;
        v.a          = ta;
        v.b          = tb_;
        v.cin        = tcin;
        v.exp_result = s[W-1:0];
        v.exp_cout   = s[W];
        v.exp_ovf    = (ta[W-1] == tb_[W-1]) && (s[W-1] != ta[W-1]);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Pulse start with the given operands, then watch NIBBLES+3 cycles.
    // repulse_at / rst_at (0 = never) inject a start or reset at that cycle.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tcin, input int repulse_at,
                                 input int rst_at);
        @(negedge clk);
        a     = ta;
        b     = tb_;
        cin   = tcin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom_range(0, 1));
        busy_cnt       = 0;
        done_cnt       = 0;
        done_pos       = 0;
        e_packed       = '0;
        f_packed       = '0;
        cin_packed     = '0;
        result_at_done = '0;
        for (int k = 1; k <= NIBBLES + 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_pos == 0) done_pos = k;
                result_at_done = result;
            end
            if (k <= NIBBLES) begin
                e_packed[4*(k-1) +: 4] = add_e;
                f_packed[4*(k-1) +: 4] = add_f;
                cin_packed[k-1]        = add_cin;
            end
            if (k == repulse_at) begin
                a     = '1;
                b     = '1;
                start = 1'b1;
            end
            if (k == rst_at) rst = 1'b1;
        end
    endtask

    task automatic checkRun(input vec_t v);
        checkOutput({v.name, " result@done"}, 64'(result_at_done), 64'(v.exp_result));
        checkOutput({v.name, " result held"}, 64'(result), 64'(v.exp_result));
        checkOutput({v.name, " cout"}, 64'(cout), 64'(v.exp_cout));
        checkOutput({v.name, " overflow"}, 64'(overflow), 64'(v.exp_ovf));
        checkOutput({v.name, " busy cycles"}, 64'(busy_cnt), 64'(NIBBLES));
        checkOutput({v.name, " done pulses"}, 64'(done_cnt), 64'd1);
        checkOutput({v.name, " done cycle"}, 64'(done_pos), 64'(NIBBLES + 1));
        checkOutput({v.name, " add_e seq"}, 64'(e_packed), 64'(v.a));
        checkOutput({v.name, " add_f seq"}, 64'(f_packed), 64'(v.b));
        checkOutput({v.name, " add_cin seq"}, 64'(cin_packed),
                    64'(carryModel(v.a, v.b, v.cin)));
    endtask

    initial begin
        vec_t v;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset result", 64'(result), 64'd0);
        checkOutput("reset cout", 64'(cout), 64'd0);
        checkOutput("reset overflow", 64'(overflow), 64'd0);
        checkOutput("reset add_e", 64'(add_e), 64'd0);
        checkOutput("reset add_cin", 64'(add_cin), 64'd0);
        rst = 1'b0;

        vecs.push_back('{"basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0});
        vecs.push_back('{"ripple",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{"posovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{"negovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{"cinonly",  16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{"cinchain", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0});
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(refModel($sformatf("rand%0d", i), W'($urandom), W'($urandom),
                                    1'($urandom_range(0, 1))));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v.a, v.b, v.cin, 0, 0);
            checkRun(v);
        end

        // A second start during RUN must be dropped, not queued
        applyStimulus(16'h1111, 16'h2222, 1'b0, 2, 0);
        checkRun('{"ignore_start", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0});

        // Reset in the second RUN cycle aborts with no done pulse
        applyStimulus(16'hAAAA, 16'h5555, 1'b0, 0, 2);
        checkOutput("midrst done pulses", 64'(done_cnt), 64'd0);
        checkOutput("midrst busy cycles", 64'(busy_cnt), 64'd2);
        checkOutput("midrst result", 64'(result), 64'd0);
        checkOutput("midrst cout", 64'(cout), 64'd0);
        checkOutput("midrst overflow", 64'(overflow), 64'd0);
        checkOutput("midrst add_e", 64'(add_e), 64'd0);

        applyStimulus(16'hAAAA, 16'h5555, 1'b0, 0, 0);
        checkRun('{"after_rst", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
